// File: rtl/pll_cfg_pkg.sv
// pll_cfg_pkg: shared state encoding, divider ranges and select encoding for pll_dyn_cfg
package pll_cfg_pkg;
  typedef enum logic [2:0] {S_IDLE, S_APPLY, S_RESET, S_WAIT_LOCK, S_STABLE, S_FAIL} state_e;
  localparam int IDIV_MIN  = 1;
  localparam int IDIV_MAX  = 64;
  localparam int FBDIV_MIN = 1;
  localparam int FBDIV_MAX = 64;
  localparam int MDIV_MIN  = 2;
  localparam int MDIV_MAX  = 128;
  localparam int ODIV_MIN  = 1;
  localparam int ODIV_MAX  = 128;
  // A width-bit field holding 0 stands for 2^width, so select = (2^width - N) mod 2^width.
  function automatic logic [6:0] sel_enc(input logic [6:0] value, input int unsigned width);
    logic [7:0] full;
    full = 8'd1 << width;
    return 7'((full - {1'b0, value}) & (full - 8'd1));
  endfunction
  function automatic logic in_range(input logic [6:0] value, input int unsigned width, input int lo, input int hi);
    int n;
    n = (value == 7'd0) ? (1 << width) : int'(value);
    return (n >= lo) && (n <= hi);
  endfunction
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer bringing the asynchronous PLL lock into the clk domain
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic s1_q;
  // shift the async input through two flops
  always_ff @(posedge clk)
    if (rst) {q, s1_q} <= 2'b00;
    else     {q, s1_q} <= {s1_q, d};
endmodule

// File: rtl/pll_dyn_cfg.sv
// pll_dyn_cfg: sequences dynamic divider reconfiguration, reset and lock confirmation of a PLL
module pll_dyn_cfg
  import pll_cfg_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 3,
  parameter int DEF_IDIV      = 1,
  parameter int DEF_FBDIV     = 1,
  parameter int DEF_MDIV      = 16,
  parameter int DEF_ODIV0     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [5:0] cfg_idiv,
  input  logic [5:0] cfg_fbdiv,
  input  logic [6:0] cfg_mdiv,
  input  logic [6:0] cfg_odiv0,
  input  logic       pll_lock,
  output logic [5:0] pll_idsel,
  output logic [5:0] pll_fbdsel,
  output logic [6:0] pll_mdsel,
  output logic [6:0] pll_odsel0,
  output logic       pll_rst,
  output logic       pll_pwd,
  output logic       locked,
  output logic       done,
  output logic       err
);
  localparam int RW = $clog2(RST_CYCLES) + 1;
  localparam int TW = $clog2(LOCK_TIMEOUT) + 1;
  localparam int SW = $clog2(STABLE_CYCLES) + 1;
  localparam int AW = $clog2(MAX_RETRY) + 1;
  localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [AW-1:0] ATT_MAX   = AW'(MAX_RETRY);
  localparam logic [5:0] DEF_ID = 6'(DEF_IDIV);
  localparam logic [5:0] DEF_FB = 6'(DEF_FBDIV);
  localparam logic [6:0] DEF_M  = 7'(DEF_MDIV);
  localparam logic [6:0] DEF_O  = 7'(DEF_ODIV0);

  state_e state_q, state_d;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [SW-1:0] stab_q, stab_d;
  logic [AW-1:0] attempt_q, attempt_d;
  logic [5:0] idiv_q, idiv_d, fbdiv_q, fbdiv_d, idsel_q, idsel_d, fbdsel_q, fbdsel_d;
  logic [6:0] mdiv_q, mdiv_d, odiv_q, odiv_d, mdsel_q, mdsel_d, odsel_q, odsel_d;
  logic pll_rst_q, pll_rst_d, ready_q, ready_d, locked_q, locked_d;
  logic conf_q, conf_d, done_q, done_d, err_q, err_d;
  logic lock_s, req_ok;

  sync2 u_sync (.clk(clk), .rst(rst), .d(pll_lock), .q(lock_s));

  assign req_ok = in_range({1'b0, cfg_idiv}, 6, IDIV_MIN, IDIV_MAX)
               && in_range({1'b0, cfg_fbdiv}, 6, FBDIV_MIN, FBDIV_MAX)
               && in_range(cfg_mdiv, 7, MDIV_MIN, MDIV_MAX)
               && in_range(cfg_odiv0, 7, ODIV_MIN, ODIV_MAX);

  // next-state, counters and registered outputs of the reconfiguration sequencer
  always_comb begin
    state_d = state_q;
    rst_cnt_d = rst_cnt_q;
    tmo_d = tmo_q;
    stab_d = stab_q;
    attempt_d = attempt_q;
    idiv_d = idiv_q;
    fbdiv_d = fbdiv_q;
    mdiv_d = mdiv_q;
    odiv_d = odiv_q;
    idsel_d = idsel_q;
    fbdsel_d = fbdsel_q;
    mdsel_d = mdsel_q;
    odsel_d = odsel_q;
    pll_rst_d = pll_rst_q;
    ready_d = ready_q;
    locked_d = locked_q;
    conf_d = conf_q;
    done_d = 1'b0;
    err_d = err_q;
    case (state_q)
      S_IDLE: begin
        locked_d = conf_q & lock_s;
        if (cfg_valid && ready_q) begin
          if (req_ok) begin
            state_d = S_APPLY;
            ready_d = 1'b0;
            locked_d = 1'b0;
            conf_d = 1'b0;
            err_d = 1'b0;
            idiv_d = cfg_idiv;
            fbdiv_d = cfg_fbdiv;
            mdiv_d = cfg_mdiv;
            odiv_d = cfg_odiv0;
          end else begin
            err_d = 1'b1;
            done_d = 1'b1;
          end
        end
      end
      S_APPLY: begin
        state_d = S_RESET;
        pll_rst_d = 1'b1;
        rst_cnt_d = '0;
        tmo_d = '0;
        attempt_d = AW'(1);
        idsel_d = 6'(sel_enc({1'b0, idiv_q}, 6));
        fbdsel_d = 6'(sel_enc({1'b0, fbdiv_q}, 6));
        mdsel_d = sel_enc(mdiv_q, 7);
        odsel_d = sel_enc(odiv_q, 7);
      end
      S_RESET: begin
        rst_cnt_d = rst_cnt_q + RW'(1);
        if (rst_cnt_q == RST_LAST) begin
          state_d = S_WAIT_LOCK;
          pll_rst_d = 1'b0;
          tmo_d = '0;
        end
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = S_STABLE;
          stab_d = '0;
        end else if (tmo_q == TMO_LAST) begin
          if (attempt_q < ATT_MAX) begin
            state_d = S_RESET;
            attempt_d = attempt_q + AW'(1);
            pll_rst_d = 1'b1;
            rst_cnt_d = '0;
          end else state_d = S_FAIL;
        end else tmo_d = tmo_q + TW'(1);
      end
      S_STABLE: begin
        if (!lock_s) state_d = S_WAIT_LOCK;
        else if (stab_q == STAB_LAST) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
          locked_d = 1'b1;
          conf_d = 1'b1;
          done_d = 1'b1;
        end else stab_d = stab_q + SW'(1);
      end
      S_FAIL: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
        locked_d = 1'b0;
        conf_d = 1'b0;
        err_d = 1'b1;
        done_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // state registers; reset restarts the default divider lock sequence
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RESET;
      rst_cnt_q <= '0;
      tmo_q <= '0;
      stab_q <= '0;
      attempt_q <= AW'(1);
      idiv_q <= DEF_ID;
      fbdiv_q <= DEF_FB;
      mdiv_q <= DEF_M;
      odiv_q <= DEF_O;
      idsel_q <= 6'(sel_enc({1'b0, DEF_ID}, 6));
      fbdsel_q <= 6'(sel_enc({1'b0, DEF_FB}, 6));
      mdsel_q <= sel_enc(DEF_M, 7);
      odsel_q <= sel_enc(DEF_O, 7);
      pll_rst_q <= 1'b1;
      ready_q <= 1'b0;
      locked_q <= 1'b0;
      conf_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rst_cnt_q <= rst_cnt_d;
      tmo_q <= tmo_d;
      stab_q <= stab_d;
      attempt_q <= attempt_d;
      idiv_q <= idiv_d;
      fbdiv_q <= fbdiv_d;
      mdiv_q <= mdiv_d;
      odiv_q <= odiv_d;
      idsel_q <= idsel_d;
      fbdsel_q <= fbdsel_d;
      mdsel_q <= mdsel_d;
      odsel_q <= odsel_d;
      pll_rst_q <= pll_rst_d;
      ready_q <= ready_d;
      locked_q <= locked_d;
      conf_q <= conf_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end

  assign cfg_ready = ready_q;
  assign pll_idsel = idsel_q;
  assign pll_fbdsel = fbdsel_q;
  assign pll_mdsel = mdsel_q;
  assign pll_odsel0 = odsel_q;
  assign pll_rst = pll_rst_q;
  assign pll_pwd = 1'b0;
  assign locked = locked_q;
  assign done = done_q;
  assign err = err_q;
endmodule

// File: tb/tb_pll_dyn_cfg.sv
// tb_pll_dyn_cfg: randomized scenario bench for pll_dyn_cfg against an arithmetic timing/encoding model
module tb_pll_dyn_cfg;
  localparam int RSTC = 16;
  localparam int TMO = 2000;
  localparam int STAB = 1024;
  localparam int RETRY = 3;

  logic clk = 1'b0, rst = 1'b1, cfg_valid = 1'b0, pll_lock = 1'b0;
  logic [5:0] cfg_idiv = 6'd1, cfg_fbdiv = 6'd1;
  logic [6:0] cfg_mdiv = 7'd2, cfg_odiv0 = 7'd1;
  logic cfg_ready, pll_rst, pll_pwd, locked, done, err;
  logic [5:0] pll_idsel, pll_fbdsel;
  logic [6:0] pll_mdsel, pll_odsel0;
  logic [25:0] sels, exp_sel;
  logic exp_locked = 1'b0;
  int vectors = 0, miscompares = 0;

  pll_dyn_cfg #(.RST_CYCLES(RSTC), .LOCK_TIMEOUT(TMO), .STABLE_CYCLES(STAB), .MAX_RETRY(RETRY)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_idiv(cfg_idiv), .cfg_fbdiv(cfg_fbdiv), .cfg_mdiv(cfg_mdiv), .cfg_odiv0(cfg_odiv0),
    .pll_lock(pll_lock), .pll_idsel(pll_idsel), .pll_fbdsel(pll_fbdsel), .pll_mdsel(pll_mdsel),
    .pll_odsel0(pll_odsel0), .pll_rst(pll_rst), .pll_pwd(pll_pwd), .locked(locked), .done(done), .err(err));

  always #10 clk = ~clk;
  assign sels = {pll_idsel, pll_fbdsel, pll_mdsel, pll_odsel0};

  function automatic int enc(input int n, input int w);
    return ((1 << w) - n) % (1 << w);
  endfunction

  task automatic set_exp(input int i, input int f, input int m, input int o);
    exp_sel = {6'(enc(i, 6)), 6'(enc(f, 6)), 7'(enc(m, 7)), 7'(enc(o, 7))};
  endtask

  task automatic drive_req(input int i, input int f, input int m, input int o);
    cfg_idiv = 6'(i);
    cfg_fbdiv = 6'(f);
    cfg_mdiv = 7'(m);
    cfg_odiv0 = 7'(o);
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic count_rst(output int n);
    n = 0;
    while (pll_rst === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_locked(output int n);
    n = 0;
    while (locked !== 1'b1 && n < 3 * STAB + TMO) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    set_exp(1, 1, 16, 8);
    exp_locked = 1'b0;
    vectors++;
    if (sels !== exp_sel) begin miscompares++; $display("FAIL reset_sel got %h want %h", sels, exp_sel); end
    vectors++;
    if ({pll_rst, pll_pwd, cfg_ready, locked, done, err} !== 6'b100000)
      begin miscompares++; $display("FAIL reset_out rst/pwd/rdy/lk/done/err got %b want 100000", {pll_rst, pll_pwd, cfg_ready, locked, done, err}); end
  endtask

  task automatic test_powerup();
    int n;
    rst = 1'b0;
    count_rst(n);
    vectors++;
    if (n != RSTC) begin miscompares++; $display("FAIL pwrup_rst_len got %0d want %0d", n, RSTC); end
    repeat (200 - RSTC) @(negedge clk);
    pll_lock = 1'b1;
    wait_locked(n);
    vectors++;
    if (n != STAB + 3) begin miscompares++; $display("FAIL pwrup_lock_lat got %0d want %0d", n, STAB + 3); end
    vectors++;
    if ({done, err, cfg_ready, sels} !== {3'b101, exp_sel})
      begin miscompares++; $display("FAIL pwrup_done done/err/rdy/sel got %b %h want 101 %h", {done, err, cfg_ready}, sels, exp_sel); end
    exp_locked = 1'b1;
    @(negedge clk);
    vectors++;
    if ({done, locked} !== 2'b01) begin miscompares++; $display("FAIL pwrup_pulse done/locked got %b want 01", {done, locked}); end
  endtask

  task automatic reconfig(input int i, input int f, input int m, input int o, input int dly, input int glitch);
    int n;
    drive_req(i, f, m, o);
    vectors++;
    if ({cfg_ready, locked, err} !== 3'b000) begin miscompares++; $display("FAIL accept_t1 rdy/lk/err got %b want 000", {cfg_ready, locked, err}); end
    vectors++;
    if (sels !== exp_sel) begin miscompares++; $display("FAIL sel_hold_t1 got %h want %h", sels, exp_sel); end
    set_exp(i, f, m, o);
    exp_locked = 1'b0;
    @(negedge clk);
    vectors++;
    if ({sels, pll_rst} !== {exp_sel, 1'b1}) begin miscompares++; $display("FAIL sel_apply_t2 sel/rst got %h %b want %h 1", sels, pll_rst, exp_sel); end
    pll_lock = 1'b0;
    count_rst(n);
    vectors++;
    if (n != RSTC) begin miscompares++; $display("FAIL cfg_rst_len got %0d want %0d", n, RSTC); end
    repeat (dly) @(negedge clk);
    pll_lock = 1'b1;
    if (glitch >= 0) begin
      repeat (3 + glitch) @(negedge clk);
      vectors++;
      if (locked !== 1'b0) begin miscompares++; $display("FAIL glitch_early_lock got %b want 0", locked); end
      pll_lock = 1'b0;
      @(negedge clk);
      pll_lock = 1'b1;
    end
    wait_locked(n);
    vectors++;
    if (n != STAB + 3) begin miscompares++; $display("FAIL cfg_lock_lat got %0d want %0d", n, STAB + 3); end
    vectors++;
    if ({done, err, cfg_ready} !== 3'b101) begin miscompares++; $display("FAIL cfg_done done/err/rdy got %b want 101", {done, err, cfg_ready}); end
    exp_locked = 1'b1;
    @(negedge clk);
    vectors++;
    if ({done, locked} !== 2'b01) begin miscompares++; $display("FAIL cfg_pulse done/locked got %b want 01", {done, locked}); end
  endtask

  task automatic test_random_reconfig();
    reconfig($urandom_range(1, 64), $urandom_range(1, 64), $urandom_range(2, 128), $urandom_range(1, 128), $urandom_range(0, 300), -1);
  endtask

  task automatic test_invalid();
    drive_req($urandom_range(1, 64), $urandom_range(1, 64), 1, $urandom_range(1, 128));
    vectors++;
    if ({err, done, cfg_ready, pll_rst, locked} !== {4'b1110, exp_locked})
      begin miscompares++; $display("FAIL invalid_t1 err/done/rdy/rst/lk got %b want %b", {err, done, cfg_ready, pll_rst, locked}, {4'b1110, exp_locked}); end
    vectors++;
    if (sels !== exp_sel) begin miscompares++; $display("FAIL invalid_sel got %h want %h", sels, exp_sel); end
    @(negedge clk);
    vectors++;
    if ({done, err, pll_rst} !== 3'b010) begin miscompares++; $display("FAIL invalid_t2 done/err/rst got %b want 010", {done, err, pll_rst}); end
  endtask

  task automatic test_lock_timeout();
    int n, i, f, m, o;
    i = $urandom_range(1, 64);
    f = $urandom_range(1, 64);
    m = $urandom_range(2, 128);
    o = $urandom_range(1, 128);
    drive_req(i, f, m, o);
    set_exp(i, f, m, o);
    exp_locked = 1'b0;
    pll_lock = 1'b0;
    @(negedge clk);
    for (int a = 1; a <= RETRY; a++) begin
      count_rst(n);
      vectors++;
      if (n != RSTC) begin miscompares++; $display("FAIL retry%0d_rst_len got %0d want %0d", a, n, RSTC); end
      n = 0;
      while (pll_rst !== 1'b1 && done !== 1'b1 && n < TMO + 10) begin
        @(negedge clk);
        n++;
      end
      vectors++;
      if (n != (a < RETRY ? TMO : TMO + 1)) begin miscompares++; $display("FAIL retry%0d_wait got %0d want %0d", a, n, a < RETRY ? TMO : TMO + 1); end
    end
    vectors++;
    if ({err, done, locked, cfg_ready, pll_rst, sels} !== {5'b11010, exp_sel})
      begin miscompares++; $display("FAIL timeout_end err/done/lk/rdy/rst/sel got %b %h want 11010 %h", {err, done, locked, cfg_ready, pll_rst}, sels, exp_sel); end
    @(negedge clk);
    vectors++;
    if ({done, err} !== 2'b01) begin miscompares++; $display("FAIL timeout_pulse done/err got %b want 01", {done, err}); end
  endtask

  task automatic test_rst_mid();
    int n;
    drive_req($urandom_range(1, 64), $urandom_range(1, 64), $urandom_range(2, 128), $urandom_range(1, 128));
    @(negedge clk);
    pll_lock = 1'b0;
    count_rst(n);
    repeat ($urandom_range(5, 500)) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    set_exp(1, 1, 16, 8);
    exp_locked = 1'b0;
    vectors++;
    if (sels !== exp_sel) begin miscompares++; $display("FAIL midrst_sel got %h want %h", sels, exp_sel); end
    vectors++;
    if ({pll_rst, done, locked, cfg_ready, err} !== 5'b10000)
      begin miscompares++; $display("FAIL midrst_out rst/done/lk/rdy/err got %b want 10000", {pll_rst, done, locked, cfg_ready, err}); end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL midrst_no_done got %b want 0", done); end
    test_powerup();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_powerup();
    reconfig(2, 3, 24, 6, 50, -1);
    test_invalid();
    test_random_reconfig();
    test_lock_glitch_wrap();
    test_lock_timeout();
    test_invalid();
    for (int k = 0; k < 5; k++) begin
      if ($urandom_range(0, 3) == 0) test_invalid();
      test_random_reconfig();
    end
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  task automatic test_lock_glitch_wrap();
    reconfig($urandom_range(1, 64), $urandom_range(1, 64), $urandom_range(2, 128), $urandom_range(1, 128), $urandom_range(0, 100), 500);
  endtask
endmodule
